// File: rtl/harvos_dma_mem_responder.sv
// Responder end of the DMA firewall path: word-addressed RAM window with byte-enable writes,
// programmable wait states and range/alignment fault checks. HARVOS_DMA_RESP_ERRINJ_EN adds err_inject.
module harvos_dma_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter logic [31:0] RAM_BYTES   = 32'd4096,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fw_req,
    input  logic        fw_we,
    input  logic [3:0]  fw_be,
    input  logic [31:0] fw_addr,
    input  logic [31:0] fw_wdata,
`ifdef HARVOS_DMA_RESP_ERRINJ_EN
    input  logic        err_inject,
`endif
    output logic [31:0] m_rdata,
    output logic        m_rvalid,
    output logic        m_fault,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    localparam int unsigned Depth    = ((RAM_BYTES >> 2) > 0) ? int'(RAM_BYTES >> 2) : 1;
    localparam int unsigned IdxW     = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [3:0]  WaitInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    if (RAM_BYTES % 4 != 0) begin : g_bad_bytes
        $error("RAM_BYTES must be a multiple of 4");
    end
    if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
        $error("BASE_ADDR must be 4-byte aligned");
    end
    if (WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 0..15");
    end

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [3:0]        be_q;
    logic [IdxW-1:0]   idx_q;
    logic [31:0]       wdata_q;
    logic              fault_q;
    logic [31:0]       rdata_q, rdata_d;
    logic [7:0]        drop_q;
    logic [31:0]       mem [Depth];

    logic              inj;
    logic [31:0]       offset;
    logic              req_fault;
    logic [IdxW-1:0]   req_idx;
    logic              accept;
    logic              enter_resp;
    logic              commit;
    logic              cur_we;
    logic              cur_fault;
    logic [3:0]        cur_be;
    logic [IdxW-1:0]   cur_idx;
    logic [31:0]       cur_wdata;

`ifdef HARVOS_DMA_RESP_ERRINJ_EN
    assign inj = err_inject;
`else
    assign inj = 1'b0;
`endif

    // Unsigned compares: an address below the base is caught before the offset is trusted.
    assign offset    = fw_addr - BASE_ADDR;
    assign req_idx   = IdxW'(offset >> 2);
    assign req_fault = (fw_addr < BASE_ADDR) || (offset >= RAM_BYTES) ||
                       (fw_addr[1:0] != 2'b00) || (fw_be == 4'b0000) || inj;

    assign accept = (state_q == StIdle) && fw_req;

    // With zero wait states the accepting edge also enters RESP, so use the live request.
    assign cur_we    = accept ? fw_we     : we_q;
    assign cur_be    = accept ? fw_be     : be_q;
    assign cur_idx   = accept ? req_idx   : idx_q;
    assign cur_wdata = accept ? fw_wdata  : wdata_q;
    assign cur_fault = accept ? req_fault : fault_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (fw_req) begin
                    state_d = (WAIT_CYCLES > 0) ? StWait : StResp;
                    cnt_d   = WaitInit;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign enter_resp = (state_d == StResp);
    assign commit     = enter_resp && cur_we && !cur_fault;

    always_comb begin
        rdata_d = 32'h0;
        if (enter_resp && !cur_we && !cur_fault) begin
            rdata_d = mem[cur_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            fault_q <= 1'b0;
            rdata_q <= 32'h0;
            drop_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if (accept) begin
                we_q    <= fw_we;
                be_q    <= fw_be;
                idx_q   <= req_idx;
                wdata_q <= fw_wdata;
                fault_q <= req_fault;
            end
            if (fw_req && busy && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    // RAM is not reset; a reset edge suppresses a commit that would otherwise land on it.
    always_ff @(posedge clk) begin
        if (rst_n && commit) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) begin
                    mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

    assign busy     = (state_q != StIdle);
    assign m_rvalid = (state_q == StResp);
    assign m_fault  = m_rvalid && fault_q;
    assign m_rdata  = rdata_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_harvos_dma_mem_responder.sv
// Randomized self-checking bench for harvos_dma_mem_responder against a behavioural RAM model.
module tb_harvos_dma_mem_responder;

    localparam logic [31:0] Base  = 32'h0001_0000;
    localparam logic [31:0] Bytes = 32'd4096;
    localparam int          Wait  = 1;
    localparam int          Depth = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fw_req;
    logic        fw_we;
    logic [3:0]  fw_be;
    logic [31:0] fw_addr;
    logic [31:0] fw_wdata;
    logic        err_inject;
    logic [31:0] m_rdata;
    logic        m_rvalid;
    logic        m_fault;
    logic        busy;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;
    int drop_model = 0;
    logic [31:0] model_mem [Depth];

    always #5 clk = ~clk;

    harvos_dma_mem_responder #(
        .BASE_ADDR  (Base),
        .RAM_BYTES  (Bytes),
        .WAIT_CYCLES(Wait)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fw_req    (fw_req),
        .fw_we     (fw_we),
        .fw_be     (fw_be),
        .fw_addr   (fw_addr),
        .fw_wdata  (fw_wdata),
`ifdef HARVOS_DMA_RESP_ERRINJ_EN
        .err_inject(err_inject),
`endif
        .m_rdata   (m_rdata),
        .m_rvalid  (m_rvalid),
        .m_fault   (m_fault),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    // Reference: a transaction faults on range/alignment/empty-be/injection; good writes merge bytes.
    task automatic model_access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic inj,
                                output logic exp_f, output logic [31:0] exp_d);
        longint off;
        int     idx;
        off   = longint'(addr) - longint'(Base);
        exp_f = (off < 0) || (off >= longint'(Bytes)) || (addr % 4 != 0) || (be == 4'h0) || inj;
        exp_d = 32'h0;
        if (!exp_f) begin
            idx = int'(off / 4);
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                exp_d = model_mem[idx];
            end
        end
    endtask

    // Issues one request; holds fw_req for 'hold' extra edges. Observes the whole response window.
    task automatic run_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic inj, input int hold,
                           output int nvalid, output int lat, output logic [31:0] rdata,
                           output logic fault, output int viol);
        nvalid = 0; lat = -1; rdata = 32'h0; fault = 1'b0; viol = 0;
        @(negedge clk);
        fw_req = 1'b1; fw_we = we; fw_be = be; fw_addr = addr; fw_wdata = wdata; err_inject = inj;
        @(posedge clk);
        for (int c = 0; c <= Wait + 3; c++) begin
            @(negedge clk);
            if (m_rvalid === 1'b1) begin
                nvalid++; lat = c; rdata = m_rdata; fault = m_fault;
            end else if (m_rvalid !== 1'b0 || m_fault !== 1'b0 || m_rdata !== 32'h0) begin
                viol++;
            end
            if (busy !== logic'(c <= Wait)) viol++;
            if (c == hold) begin
                fw_req = 1'b0; err_inject = 1'b0;
            end
        end
        drop_model = (drop_model + hold > 255) ? 255 : drop_model + hold;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; fw_req = 1'b0; fw_we = 1'b0; fw_be = 4'h0; fw_addr = 32'h0;
        fw_wdata = 32'h0; err_inject = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", m_rvalid); end
        checks++; if (m_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", m_fault); end
        checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", m_rdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL reset_drop got %h want 00", drop_cnt); end
        rst_n = 1'b1;
        drop_model = 0;
    endtask

    // Table-driven directed accesses; each entry is checked against the model.
    task automatic test_directed(input string name, input logic we, input logic [3:0] be,
                                 input logic [31:0] addr, input logic [31:0] wdata, input logic inj);
        int nv, lat, viol; logic [31:0] rd, ed; logic f, ef;
        model_access(we, be, addr, wdata, inj, ef, ed);
        run_txn(we, be, addr, wdata, inj, 0, nv, lat, rd, f, viol);
        checks++;
        if (nv !== 1 || lat !== Wait || f !== ef || rd !== ed || viol !== 0) begin
            errors++;
            $display("FAIL %s addr=%h got valid=%0d lat=%0d fault=%b rdata=%h viol=%0d want valid=1 lat=%0d fault=%b rdata=%h",
                     name, addr, nv, lat, f, rd, viol, Wait, ef, ed);
        end
    endtask

    task automatic test_init;
        test_directed("write_base", 1'b1, 4'hF, Base, 32'hDEADBEEF, 1'b0);
        for (int w = 1; w < 16; w++)
            test_directed("init_word", 1'b1, 4'hF, Base + 32'(w * 4), $urandom, 1'b0);
        test_directed("init_last", 1'b1, 4'hF, Base + Bytes - 32'd4, $urandom, 1'b0);
        test_directed("read_base", 1'b0, 4'hF, Base, 32'h0, 1'b0);
        test_directed("read_last", 1'b0, 4'h1, Base + Bytes - 32'd4, 32'h0, 1'b0);
    endtask

    task automatic test_byte_en;
        logic [31:0] exp_word;
        test_directed("be_fill", 1'b1, 4'hF, Base + 32'd4, 32'hAAAAAAAA, 1'b0);
        test_directed("be_merge", 1'b1, 4'b0101, Base + 32'd4, 32'h11223344, 1'b0);
        exp_word = model_mem[1];
        checks++;
        if (exp_word !== 32'hAA22AA44) begin
            errors++; $display("FAIL be_model got %h want aa22aa44", exp_word);
        end
        test_directed("be_readback", 1'b0, 4'h0 | 4'h2, Base + 32'd4, 32'h0, 1'b0);
    endtask

    task automatic test_faults;
        test_directed("below_base", 1'b1, 4'hF, 32'h0000_0004, 32'h55555555, 1'b0);
        test_directed("at_limit", 1'b1, 4'hF, Base + Bytes, 32'h55555555, 1'b0);
        test_directed("misaligned", 1'b1, 4'hF, Base + 32'd2, 32'h55555555, 1'b0);
        test_directed("be_zero", 1'b1, 4'h0, Base, 32'h55555555, 1'b0);
        test_directed("far_high", 1'b1, 4'hF, 32'hFFFF_FFFC, 32'h55555555, 1'b0);
        test_directed("read_below", 1'b0, 4'hF, Base - 32'd4, 32'h0, 1'b0);
        test_directed("read_limit", 1'b0, 4'hF, Base + Bytes, 32'h0, 1'b0);
        test_directed("fault_rb0", 1'b0, 4'hF, Base, 32'h0, 1'b0);
        test_directed("fault_rb1", 1'b0, 4'hF, Base + 32'd4, 32'h0, 1'b0);
    endtask

    task automatic test_random;
        logic [31:0] addr; logic [3:0] be; int sel;
        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 9);
            be  = 4'($urandom_range(0, 15));
            if (sel <= 5)      addr = Base + 32'($urandom_range(0, 15) * 4);
            else if (sel == 6) addr = Base + Bytes - 32'd4;
            else if (sel == 7) addr = Base + 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else if (sel == 8) addr = 32'($urandom_range(0, 32'h0000_FFFF));
            else               addr = Base + Bytes + 32'($urandom_range(0, 1000) * 4);
            test_directed("random", 1'($urandom_range(0, 1)), be, addr, $urandom, 1'b0);
        end
    endtask

    task automatic test_drop;
        int nv, lat, viol; logic [31:0] rd, ed; logic f, ef;
        model_access(1'b0, 4'hF, Base, 32'h0, 1'b0, ef, ed);
        run_txn(1'b0, 4'hF, Base, 32'h0, 1'b0, 2, nv, lat, rd, f, viol);
        checks++;
        if (nv !== 1 || f !== ef || rd !== ed || viol !== 0) begin
            errors++;
            $display("FAIL drop_single got valid=%0d fault=%b rdata=%h viol=%0d want valid=1 fault=%b rdata=%h",
                     nv, f, rd, viol, ef, ed);
        end
        checks++;
        if (drop_cnt !== 8'(drop_model) || drop_model != 2) begin
            errors++; $display("FAIL drop_two got %0d want 2", drop_cnt);
        end
        for (int n = 0; n < 99; n++) run_txn(1'b0, 4'hF, Base, 32'h0, 1'b0, Wait + 1, nv, lat, rd, f, viol);
        checks++;
        if (drop_cnt !== 8'(drop_model)) begin
            errors++; $display("FAIL drop_mid got %0d want %0d", drop_cnt, drop_model);
        end
        for (int n = 0; n < 150; n++) run_txn(1'b0, 4'hF, Base, 32'h0, 1'b0, Wait + 1, nv, lat, rd, f, viol);
        checks++;
        if (drop_cnt !== 8'hFF) begin
            errors++; $display("FAIL drop_saturate got %h want ff", drop_cnt);
        end
    endtask

    task automatic test_reset_mid;
        int nv; logic busy_bad; logic [31:0] newv;
        // Reset while in WAIT: the pending write must not land.
        nv = 0; busy_bad = 1'b0;
        newv = ~model_mem[2];
        @(negedge clk);
        fw_req = 1'b1; fw_we = 1'b1; fw_be = 4'hF; fw_addr = Base + 32'd8; fw_wdata = newv;
        @(posedge clk);
        @(negedge clk);
        fw_req = 1'b0; rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (m_rvalid !== 1'b0) nv++;
            if (busy !== 1'b0) busy_bad = 1'b1;
            if (c == 0) begin
                checks++;
                if (drop_cnt !== 8'h00) begin errors++; $display("FAIL rstmid_drop got %h want 00", drop_cnt); end
                rst_n = 1'b1;
            end
        end
        drop_model = 0;
        checks++;
        if (nv !== 0 || busy_bad !== 1'b0) begin
            errors++; $display("FAIL rstmid_quiet got rvalid_cycles=%0d busy_seen=%b want 0 0", nv, busy_bad);
        end
        test_directed("rstmid_old", 1'b0, 4'hF, Base + 32'd8, 32'h0, 1'b0);

        // Reset right after RESP: the write committed on RESP entry stays.
        newv = $urandom;
        @(negedge clk);
        fw_req = 1'b1; fw_we = 1'b1; fw_be = 4'hF; fw_addr = Base + 32'd12; fw_wdata = newv;
        @(posedge clk);
        @(negedge clk);
        fw_req = 1'b0;
        repeat (Wait) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_mem[3] = newv;
        test_directed("rstresp_kept", 1'b0, 4'hF, Base + 32'd12, 32'h0, 1'b0);
    endtask

`ifdef HARVOS_DMA_RESP_ERRINJ_EN
    task automatic test_errinj;
        test_directed("inj_read", 1'b0, 4'hF, Base, 32'h0, 1'b1);
        test_directed("noinj_read", 1'b0, 4'hF, Base, 32'h0, 1'b0);
        test_directed("inj_write", 1'b1, 4'hF, Base, 32'h12345678, 1'b1);
        test_directed("inj_write_rb", 1'b0, 4'hF, Base, 32'h0, 1'b0);
    endtask
`endif

    initial begin
        test_reset;
        test_init;
        test_byte_en;
        test_faults;
        test_random;
        test_drop;
        test_reset_mid;
`ifdef HARVOS_DMA_RESP_ERRINJ_EN
        test_errinj;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
